// File: rtl/bustap_pkg.sv
// Shared constants, capture-entry layout and helpers for the bus-tap address filter.
// Entry carries a leading 16-bit timestamp when BUSTAP_CAPTURE_TIMESTAMP_EN is defined.
package bustap_pkg;
  localparam int MASK_NUM     = 16;
  localparam int MASK_VLD_BIT = 1;
  localparam int MASK_EXC_BIT = 0;
  localparam int TS_W         = 16;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;

  // Layout of one capture entry at the default bus widths; MSB first.
  typedef struct packed {
`ifdef BUSTAP_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cap_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/bustap_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit for count/full.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module bustap_sync_fifo #(
  parameter int W  = 65,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
);
  logic [W-1:0] r_mem [2**AW];
  logic [AW:0]  r_wp, r_rp;
  logic         w_push_ok, w_pop_ok;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_count   = r_wp - r_rp;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | i_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_wp[AW-1:0] == r_rp[AW-1:0] && o_empty ? '0 : r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/bustap_addr_filter_capture.sv
// Bus-tap filter: 3-stage strobe/match/push pipeline feeding an FWFT capture FIFO.
// Define BUSTAP_CAPTURE_TIMESTAMP_EN to prepend a 16-bit cycle timestamp to each entry.
module bustap_addr_filter_capture
  import bustap_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int mask_num   = MASK_NUM,
  parameter int fifo_aw    = 4,
`ifdef BUSTAP_CAPTURE_TIMESTAMP_EN
  localparam int CAP_W = TS_W + 1 + addr_width + data_width
`else
  localparam int CAP_W = 1 + addr_width + data_width
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cap_en,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [addr_width-1:0]          addr_in,
  input  logic [data_width-1:0]          data_in,
  input  logic [mask_num*addr_width-1:0] mask_flat,
  input  logic                           pop,
  output logic                           cap_valid,
  output logic [CAP_W-1:0]               cap_data,
  output logic                           fifo_full,
  output logic [fifo_aw:0]               fifo_count,
  output logic [15:0]                    drop_cnt
);
  logic [mask_num*addr_width-1:0] r_shadow;
  logic                  r_s0_vld, r_s0_wr, r_s1_vld, r_s1_qual;
  logic [addr_width-1:0] r_s0_addr;
  logic [data_width-1:0] r_s0_data;
  logic [CAP_W-1:0]      r_s1_ent, w_s0_ent;
  logic [15:0]           r_drop;
  logic w_ev, w_dual, w_hit_inc, w_hit_exc, w_any_inc, w_qual;
  logic w_push, w_empty, w_full, w_full_drop;
  logic [1:0] w_drop_inc;

`ifdef BUSTAP_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts, r_s0_ts;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end
  assign w_s0_ent = {r_s0_ts, r_s0_wr, r_s0_addr, r_s0_data};
`else
  assign w_s0_ent = {r_s0_wr, r_s0_addr, r_s0_data};
`endif

  // Masks cross from the JTAG domain; they are only trusted while capture is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_shadow <= '0;
    else if (!cap_en) r_shadow <= mask_flat;
  end

  assign w_ev   = (wr_en | rd_en) & cap_en;
  assign w_dual = wr_en & rd_en & cap_en;

  always_comb begin
    w_hit_inc = 1'b0;
    w_hit_exc = 1'b0;
    w_any_inc = 1'b0;
    for (int k = 0; k < mask_num; k++) begin
      if (r_shadow[k*addr_width + MASK_VLD_BIT]) begin
        if (r_shadow[k*addr_width + MASK_EXC_BIT]) begin
          if (r_shadow[k*addr_width+2 +: addr_width-2] == r_s0_addr[addr_width-1:2]) w_hit_exc = 1'b1;
        end else begin
          w_any_inc = 1'b1;
          if (r_shadow[k*addr_width+2 +: addr_width-2] == r_s0_addr[addr_width-1:2]) w_hit_inc = 1'b1;
        end
      end
    end
    w_qual = (w_hit_inc | ~w_any_inc) & ~w_hit_exc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_vld  <= 1'b0;
      r_s0_wr   <= 1'b0;
      r_s0_addr <= '0;
      r_s0_data <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_qual <= 1'b0;
      r_s1_ent  <= '0;
      r_drop    <= '0;
`ifdef BUSTAP_CAPTURE_TIMESTAMP_EN
      r_s0_ts   <= '0;
`endif
    end else begin
      r_s0_vld  <= w_ev;
      r_s0_wr   <= wr_en;
      r_s0_addr <= addr_in;
      r_s0_data <= data_in;
`ifdef BUSTAP_CAPTURE_TIMESTAMP_EN
      r_s0_ts   <= r_ts;
`endif
      r_s1_vld  <= r_s0_vld;
      r_s1_qual <= w_qual;
      r_s1_ent  <= w_s0_ent;
      r_drop    <= sat_add16(r_drop, w_drop_inc);
    end
  end

  // A colliding read is lost at S0; a push into a full FIFO without a pop is lost at S2.
  assign w_push      = r_s1_vld & r_s1_qual;
  assign w_full_drop = w_push & w_full & ~pop;
  assign w_drop_inc  = {1'b0, w_full_drop} + {1'b0, w_dual};

  bustap_sync_fifo #(.W(CAP_W), .AW(fifo_aw)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (r_s1_ent),
    .i_pop   (pop),
    .o_dout  (cap_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

  assign cap_valid = ~w_empty;
  assign fifo_full = w_full;
  assign drop_cnt  = r_drop;
endmodule

// File: tb/tb_bustap_addr_filter_capture.sv
// Randomised + directed bench for bustap_addr_filter_capture, checked every cycle
// against a transaction-level model (mask rule, FIFO queue, drop counter).
module tb_bustap_addr_filter_capture;
  localparam int AW = 32, DW = 32, FAW = 4, DEPTH = 16, EW = 1 + AW + DW;
`ifdef BUSTAP_CAPTURE_TIMESTAMP_EN
  localparam int CW = 16 + EW;
`else
  localparam int CW = EW;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, cap_en = 1'b0, wr_en = 1'b0, rd_en = 1'b0, pop = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [16*AW-1:0] mask_flat = '0;
  logic          cap_valid, fifo_full;
  logic [CW-1:0] cap_data;
  logic [FAW:0]  fifo_count;
  logic [15:0]   drop_cnt;

  int nchk = 0, nerr = 0;

  bustap_addr_filter_capture #(.addr_width(AW), .data_width(DW), .mask_num(16), .fifo_aw(FAW)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .wr_en(wr_en), .rd_en(rd_en),
    .addr_in(addr_in), .data_in(data_in), .mask_flat(mask_flat), .pop(pop),
    .cap_valid(cap_valid), .cap_data(cap_data), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] mq[$];
  logic [EW-1:0] pend_ent[$];
  longint        pend_due[$];
  logic [AW-1:0] shadow[16] = '{default: '0};
  int            m_drop = 0;
  longint        cyc = 0;

  function automatic bit qualifies(input logic [AW-1:0] a);
    bit hi = 0, he = 0, ai = 0;
    for (int k = 0; k < 16; k++) begin
      if (shadow[k][1]) begin
        if (shadow[k][0]) begin
          if (shadow[k][AW-1:2] == a[AW-1:2]) he = 1;
        end else begin
          ai = 1;
          if (shadow[k][AW-1:2] == a[AW-1:2]) hi = 1;
        end
      end
    end
    return (hi || !ai) && !he;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); pend_ent.delete(); pend_due.delete();
      m_drop = 0; cyc = 0;
      for (int k = 0; k < 16; k++) shadow[k] = '0;
    end else begin
      cyc++;
      if (pop && mq.size() > 0) void'(mq.pop_front());
      while (pend_due.size() > 0 && pend_due[0] == cyc) begin
        void'(pend_due.pop_front());
        if (mq.size() < DEPTH) mq.push_back(pend_ent.pop_front());
        else begin
          void'(pend_ent.pop_front());
          if (m_drop < 65535) m_drop++;
        end
      end
      if (wr_en && rd_en && cap_en && m_drop < 65535) m_drop++;
      if ((wr_en || rd_en) && cap_en && qualifies(addr_in)) begin
        pend_due.push_back(cyc + 2);
        pend_ent.push_back({wr_en, addr_in, data_in});
      end
      if (!cap_en) for (int k = 0; k < 16; k++) shadow[k] = mask_flat[k*AW +: AW];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cap_valid", 96'(cap_valid), 96'(mq.size() > 0));
      chk("fifo_count", 96'(fifo_count), 96'(mq.size()));
      chk("fifo_full", 96'(fifo_full), 96'(mq.size() == DEPTH));
      chk("drop_cnt", 96'(drop_cnt), 96'(m_drop));
      if (mq.size() > 0) chk("cap_data", 96'(cap_data[EW-1:0]), 96'(mq[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit p);
    @(negedge clk);
    wr_en = w; rd_en = r; addr_in = a; data_in = d; pop = p;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, '0, '0, 0);
  endtask

  task automatic set_mask(input int k, input logic [AW-1:0] v);
    mask_flat[k*AW +: AW] = v;
  endtask

  function automatic logic [AW-1:0] pool(input int i);
    case (i)
      0: return 32'h2000;
      1: return 32'h2004;
      2: return 32'h3000;
      default: return 32'h3004;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst cap_valid", 96'(cap_valid), 96'(0));
    chk("rst fifo_count", 96'(fifo_count), 96'(0));
    chk("rst fifo_full", 96'(fifo_full), 96'(0));
    chk("rst drop_cnt", 96'(drop_cnt), 96'(0));
    chk("rst cap_data", 96'(cap_data[EW-1:0]), 96'(0));
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // no masks: everything qualifies, latency check
    cap_en = 1'b1;
    drive(1, 0, 32'h1000, 32'hA5A5A5A5, 0);
    idle(1); chk("lat N+1", 96'(cap_valid), 96'(0));
    idle(1); chk("lat N+2", 96'(cap_valid), 96'(0));
    idle(1); chk("lat N+3", 96'(cap_valid), 96'(1));
    chk("t1 entry", 96'(cap_data[EW-1:0]), 96'({1'b1, 32'h1000, 32'hA5A5A5A5}));
    drive(0, 0, '0, '0, 1); idle(1);

    // include 0x2000
    cap_en = 1'b0; set_mask(0, 32'h0000_2002); idle(2); cap_en = 1'b1;
    drive(0, 1, 32'h2000, 32'h11, 0);
    drive(0, 1, 32'h3000, 32'h22, 0);
    idle(4);
    chk("inc count", 96'(fifo_count), 96'(1));
    chk("inc entry", 96'(cap_data[EW-1:0]), 96'({1'b0, 32'h2000, 32'h11}));
    drive(0, 0, '0, '0, 1); idle(1);

    // exclude beats include
    cap_en = 1'b0; set_mask(1, 32'h0000_2003); idle(2); cap_en = 1'b1;
    drive(1, 0, 32'h2000, 32'h33, 0);
    idle(4);
    chk("exc valid", 96'(cap_valid), 96'(0));
    chk("exc drop", 96'(drop_cnt), 96'(0));

    // fill to overflow
    cap_en = 1'b0; mask_flat = '0; idle(2); cap_en = 1'b1;
    for (int i = 0; i < 18; i++) drive(1, 0, 32'h100 + 32'(i*4), 32'(i), 0);
    idle(4);
    chk("full count", 96'(fifo_count), 96'(16));
    chk("full flag", 96'(fifo_full), 96'(1));
    chk("full drop", 96'(drop_cnt), 96'(2));

    // push and pop meet at the full FIFO
    drive(1, 0, 32'h9990, 32'hBEEF, 0);
    idle(1);
    drive(0, 0, '0, '0, 1);
    idle(1);
    chk("pp count", 96'(fifo_count), 96'(16));
    chk("pp drop", 96'(drop_cnt), 96'(2));
    for (int i = 0; i < 15; i++) drive(0, 0, '0, '0, 1);
    idle(1);
    chk("pp tail", 96'(cap_data[EW-1:0]), 96'({1'b1, 32'h9990, 32'h0000BEEF}));
    drive(0, 0, '0, '0, 1); idle(1);
    chk("drained", 96'(cap_valid), 96'(0));

    // shadow masks frozen while capturing
    cap_en = 1'b0; set_mask(0, 32'h0000_2002); idle(2); cap_en = 1'b1;
    set_mask(0, 32'h0000_3002);
    drive(1, 0, 32'h3000, 32'h44, 0);
    idle(4);
    chk("frozen", 96'(cap_valid), 96'(0));
    cap_en = 1'b0; idle(2); cap_en = 1'b1;
    drive(1, 0, 32'h3000, 32'h55, 0);
    idle(4);
    chk("reload", 96'(fifo_count), 96'(1));
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h3000, 32'(i), 0);
    idle(4);
    chk("pre-rst count", 96'(fifo_count), 96'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 96'(cap_valid), 96'(0));
    chk("async rst count", 96'(fifo_count), 96'(0));
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n % 200 == 0) begin
        cap_en = 1'b0;
        for (int k = 0; k < 16; k++)
          set_mask(k, ($urandom_range(0, 3) == 0) ? (pool($urandom_range(0, 3)) | 32'($urandom_range(0, 3))) : 32'h0);
        idle(2);
        cap_en = 1'b1;
      end
      if (n % 333 == 100) set_mask($urandom_range(0, 15), pool($urandom_range(0, 3)) | 32'h2);
      r = $urandom_range(0, 9);
      drive(r < 3 || r == 6, (r >= 3 && r < 7), pool($urandom_range(0, 3)) | 32'($urandom_range(0, 3)),
            $urandom, $urandom_range(0, 3) == 0);
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
